// File: rtl/store_buffer_if.sv
// Signal bundle between the CPU/memory side and store_buffer.
// The master modport is the environment; the slave modport is the buffer itself.
interface store_buffer_if;
  logic [15:0] Cpu_Adr;
  logic        Cpu_Wr;
  logic        Cpu_Rd;
  logic [15:0] Cpu_Din;
  logic [15:0] Cpu_Dout;
  logic        Cpu_Stall;
  logic        Flush;
  logic        Flush_Done;
  logic [15:0] Mem_Adr;
  logic        Mem_Wr;
  logic        Mem_Rd;
  logic [15:0] Mem_Di;
  logic [15:0] Mem_Do;

  modport master (
    output Cpu_Adr, Cpu_Wr, Cpu_Rd, Cpu_Din, Flush, Mem_Do,
    input  Cpu_Dout, Cpu_Stall, Flush_Done, Mem_Adr, Mem_Wr, Mem_Rd, Mem_Di
  );

  modport slave (
    input  Cpu_Adr, Cpu_Wr, Cpu_Rd, Cpu_Din, Flush, Mem_Do,
    output Cpu_Dout, Cpu_Stall, Flush_Done, Mem_Adr, Mem_Wr, Mem_Rd, Mem_Di
  );
endinterface

// File: rtl/store_buffer.sv
// Write-posting FIFO in front of the 16-bit data memory with load lookup and flush handshake.
// Define STORE_BUFFER_FORWARD_EN to forward loads from buffered stores instead of stalling on a hit.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic           Clock_Puls,
  input logic           Reset_n,
  store_buffer_if.slave bus
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [15:0]      adr_q  [DEPTH];
  logic [15:0]      adr_d  [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [15:0]      data_d [DEPTH];
  logic             flush_done_q, flush_done_d;

  logic        full;
  logic        flushing;
  logic        rd_block;
  logic        stall;
  logic        read_go;
  logic        drain;
  logic        push;
  logic [15:0] load_data;

`ifdef STORE_BUFFER_FORWARD_EN
  logic             fwd_hit;
  logic [15:0]      fwd_data;
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to newest so the youngest matching store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (valid_q[fwd_idx] && (adr_q[fwd_idx] == bus.Cpu_Adr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign rd_block  = 1'b0;
  assign load_data = fwd_hit ? fwd_data : bus.Mem_Do;
`else
  logic addr_match;

  // Without forwarding, a load that hits a buffered store waits for it to drain.
  always_comb begin
    addr_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (adr_q[i] == bus.Cpu_Adr)) begin
        addr_match = 1'b1;
      end
    end
  end

  assign rd_block  = bus.Cpu_Rd & addr_match;
  assign load_data = bus.Mem_Do;
`endif

  always_comb begin
    full     = (count_q == FULL_CNT);
    flushing = (state_q == FLUSH);
    stall    = (bus.Cpu_Wr | bus.Cpu_Rd) & (flushing | full | rd_block);
    read_go  = bus.Cpu_Rd & ~stall;
    drain    = (count_q != '0) & ~read_go;
    push     = bus.Cpu_Wr & ~stall;
  end

  // Everything facing the CPU and memory is forced quiet while reset is held.
  always_comb begin
    bus.Mem_Wr    = 1'b0;
    bus.Mem_Rd    = 1'b0;
    bus.Mem_Adr   = '0;
    bus.Mem_Di    = '0;
    bus.Cpu_Stall = 1'b0;
    bus.Cpu_Dout  = '0;
    if (Reset_n) begin
      bus.Cpu_Stall = stall;
      if (drain) begin
        bus.Mem_Wr  = 1'b1;
        bus.Mem_Adr = adr_q[head_q];
        bus.Mem_Di  = data_q[head_q];
      end else if (read_go) begin
        bus.Mem_Rd  = 1'b1;
        bus.Mem_Adr = bus.Cpu_Adr;
      end
      if (read_go) begin
        bus.Cpu_Dout = load_data;
      end
    end
  end

  assign bus.Flush_Done = flush_done_q;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    valid_d      = valid_q;
    adr_d        = adr_q;
    data_d       = data_q;
    state_d      = state_q;
    flush_done_d = 1'b0;

    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      adr_d[tail_q]   = bus.Cpu_Adr;
      data_d[tail_q]  = bus.Cpu_Din;
      tail_d          = tail_q + 1'b1;
    end
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(drain);

    // Flush_Done fires in the cycle after the last entry leaves.
    case (state_q)
      IDLE: begin
        if (bus.Flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (count_d == '0) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_Puls or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      adr_q        <= '{default: '0};
      data_q       <= '{default: '0};
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      adr_q        <= adr_d;
      data_q       <= data_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based model of the buffer and a reference memory image.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] adr;
    logic [15:0] data;
  } entry_t;

  logic clk;
  logic rstN;

  store_buffer_if sbIf ();

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .Clock_Puls (clk),
    .Reset_n    (rstN),
    .bus        (sbIf)
  );

  logic [15:0] mem [1024];

  assign sbIf.Mem_Do = mem[sbIf.Mem_Adr[9:0]];

  // Data memory: combinational read, write on the rising edge.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      if (sbIf.Mem_Wr) mem[sbIf.Mem_Adr[9:0]] <= sbIf.Mem_Di;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t      sbQ[$];
  logic [15:0] refMem [1024];
  bit          refFlushing;
  bit          refDone;
  bit          expStall;
  bit          expDrain;

  logic        curWr, curRd, curFlush;
  logic [15:0] curAdr, curDin;

  logic        lastStall, lastMemWr, lastDone;
  logic [15:0] lastDout, lastMemAdr, lastMemDi;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    assert (got === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every DUT output against what the queue model predicts for the current inputs.
  task automatic checkOutput();
    bit          fwdHit;
    bit          matchAny;
    bit          accept;
    logic [15:0] fwdData;
    logic [15:0] expDout;
    logic [15:0] expAdr;
    logic [15:0] expDi;
    fwdHit   = 0;
    matchAny = 0;
    fwdData  = '0;
    foreach (sbQ[i]) begin
      if (sbQ[i].adr == curAdr) begin
        matchAny = 1;
        fwdHit   = 1;
        fwdData  = sbQ[i].data;
      end
    end
`ifdef STORE_BUFFER_FORWARD_EN
    expStall = (curWr || curRd) && (refFlushing || sbQ.size() == DEPTH);
`else
    expStall = (curWr || curRd) && (refFlushing || sbQ.size() == DEPTH || (curRd && matchAny));
`endif
    accept   = curRd && !expStall;
    expDrain = (sbQ.size() > 0) && !accept;
    expDout  = '0;
    if (accept) expDout = fwdHit ? fwdData : refMem[curAdr[9:0]];
    expAdr = '0;
    expDi  = '0;
    if (expDrain) begin
      expAdr = sbQ[0].adr;
      expDi  = sbQ[0].data;
    end else if (accept) begin
      expAdr = curAdr;
    end

    lastStall  = sbIf.Cpu_Stall;
    lastMemWr  = sbIf.Mem_Wr;
    lastDone   = sbIf.Flush_Done;
    lastDout   = sbIf.Cpu_Dout;
    lastMemAdr = sbIf.Mem_Adr;
    lastMemDi  = sbIf.Mem_Di;

    checkEq("Cpu_Stall",  16'(sbIf.Cpu_Stall),  16'(expStall));
    checkEq("Cpu_Dout",   sbIf.Cpu_Dout,        expDout);
    checkEq("Mem_Wr",     16'(sbIf.Mem_Wr),     16'(expDrain));
    checkEq("Mem_Rd",     16'(sbIf.Mem_Rd),     16'(accept));
    checkEq("Mem_Adr",    sbIf.Mem_Adr,         expAdr);
    checkEq("Mem_Di",     sbIf.Mem_Di,          expDi);
    checkEq("Flush_Done", 16'(sbIf.Flush_Done), 16'(refDone));
  endtask

  // Drive one cycle of CPU inputs, check at the falling edge, then advance the model.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] adr,
                               input logic [15:0] din, input logic flush);
    curWr = wr; curRd = rd; curAdr = adr; curDin = din; curFlush = flush;
    sbIf.Cpu_Wr  = wr;
    sbIf.Cpu_Rd  = rd;
    sbIf.Cpu_Adr = adr;
    sbIf.Cpu_Din = din;
    sbIf.Flush   = flush;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    if (expDrain) begin
      refMem[sbQ[0].adr[9:0]] = sbQ[0].data;
      void'(sbQ.pop_front());
    end
    if (wr && !expStall) sbQ.push_back('{adr: adr, data: din});
    refDone = 0;
    if (refFlushing) begin
      if (sbQ.size() == 0) begin
        refFlushing = 0;
        refDone     = 1;
      end
    end else if (flush) begin
      refFlushing = 1;
    end
    #1;
  endtask

  task automatic drainIdle();
    for (int k = 0; k < 20; k++) begin
      if (sbQ.size() == 0 && !refFlushing && !refDone) break;
      applyStimulus(0, 0, 16'h0, 16'h0, 0);
    end
  endtask

  initial begin
    int wrSeen;
    int doneSeen;
    int stallSeen;
    logic        rw, rr, rf;
    logic [15:0] ra, rdin;

    for (int i = 0; i < 1024; i++) refMem[i] = '0;
    refFlushing = 0;
    refDone     = 0;
    lastStall   = 0;

    // Reset with a load request pending: every output must stay quiet.
    rstN = 1'b0;
    sbIf.Cpu_Wr = 0; sbIf.Cpu_Rd = 1; sbIf.Cpu_Adr = 16'h0100;
    sbIf.Cpu_Din = 16'h0; sbIf.Flush = 0;
    #3;
    checkEq("rst Mem_Wr",     16'(sbIf.Mem_Wr),     16'h0);
    checkEq("rst Mem_Rd",     16'(sbIf.Mem_Rd),     16'h0);
    checkEq("rst Mem_Adr",    sbIf.Mem_Adr,         16'h0);
    checkEq("rst Mem_Di",     sbIf.Mem_Di,          16'h0);
    checkEq("rst Cpu_Stall",  16'(sbIf.Cpu_Stall),  16'h0);
    checkEq("rst Cpu_Dout",   sbIf.Cpu_Dout,        16'h0);
    checkEq("rst Flush_Done", 16'(sbIf.Flush_Done), 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b1;
    $display("[TB] reset released");

    // Single store, drained on the following idle cycle.
    applyStimulus(1, 0, 16'h0010, 16'hBEEF, 0);
    checkEq("st0 no write yet", 16'(lastMemWr), 16'h0);
    applyStimulus(0, 0, 16'h0, 16'h0, 0);
    checkEq("st0 drain Mem_Wr",  16'(lastMemWr), 16'h1);
    checkEq("st0 drain Mem_Adr", lastMemAdr,     16'h0010);
    checkEq("st0 drain Mem_Di",  lastMemDi,      16'hBEEF);
    applyStimulus(0, 0, 16'h0, 16'h0, 0);
    checkEq("st0 empty", 16'(lastMemWr), 16'h0);
    checkEq("st0 memory", mem[16'h0010], 16'hBEEF);

    // Preload 1..4 with 0x1111, then fill the buffer with store+load cycles.
    for (int k = 1; k <= 4; k++) applyStimulus(1, 0, 16'(k), 16'h1111, 0);
    drainIdle();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 1, 16'(k), 16'hA000 + 16'(k), 0);
      checkEq("fill load", lastDout, 16'h1111);
    end
    applyStimulus(1, 0, 16'h0005, 16'hA005, 0);
    checkEq("full stall",     16'(lastStall), 16'h1);
    checkEq("full drain adr", lastMemAdr,     16'h0001);
    applyStimulus(1, 0, 16'h0005, 16'hA005, 0);
    checkEq("full accept",    16'(lastStall), 16'h0);
    drainIdle();

    // Two stores to 0x0020 behind an older entry, then a load of 0x0020.
    applyStimulus(1, 1, 16'h0021, 16'h2121, 0);
    applyStimulus(1, 1, 16'h0022, 16'h2222, 0);
    applyStimulus(1, 1, 16'h0020, 16'hAAAA, 0);
    applyStimulus(1, 0, 16'h0020, 16'h5555, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 16'h0020, 16'h0, 0);
      if (!lastStall) break;
    end
    checkEq("hit load accepted", 16'(lastStall), 16'h0);
    checkEq("hit load data",     lastDout,       16'h5555);
    drainIdle();

    // Flush with three entries while the CPU keeps requesting.
    applyStimulus(1, 1, 16'h0070, 16'h7070, 0);
    applyStimulus(1, 1, 16'h0071, 16'h7171, 0);
    applyStimulus(1, 1, 16'h0072, 16'h7272, 0);
    applyStimulus(0, 1, 16'h0073, 16'h0, 1);
    wrSeen = 0; doneSeen = 0; stallSeen = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 16'h0060, 16'h6666, 0);
      if (lastMemWr) wrSeen++;
      if (lastDone)  doneSeen++;
      if (lastStall) stallSeen++;
      if (!lastStall) break;
    end
    applyStimulus(0, 0, 16'h0, 16'h0, 0);
    if (lastDone) doneSeen++;
    checkEq("flush writes",     16'(wrSeen),    16'd3);
    checkEq("flush stalls",     16'(stallSeen), 16'd3);
    checkEq("flush done count", 16'(doneSeen),  16'd1);
    drainIdle();

    // Asynchronous reset between edges with two entries buffered.
    applyStimulus(1, 1, 16'h0050, 16'h5050, 0);
    applyStimulus(1, 1, 16'h0051, 16'h5151, 0);
    sbIf.Cpu_Wr = 0; sbIf.Cpu_Rd = 0; sbIf.Flush = 0;
    #2;
    checkEq("pre-reset Mem_Wr", 16'(sbIf.Mem_Wr), 16'h1);
    rstN = 1'b0;
    #1;
    checkEq("mid-reset Mem_Wr",  16'(sbIf.Mem_Wr), 16'h0);
    checkEq("mid-reset Mem_Adr", sbIf.Mem_Adr,     16'h0);
    rstN = 1'b1;
    sbQ.delete();
    refFlushing = 0;
    refDone     = 0;
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 16'h0, 16'h0, 0);
    checkEq("reset mem 0x50", mem[16'h0050], 16'h0);
    checkEq("reset mem 0x51", mem[16'h0051], 16'h0);

    // Same-cycle load and store: load sees the old value.
    applyStimulus(1, 0, 16'h0030, 16'h0007, 0);
    drainIdle();
    applyStimulus(1, 1, 16'h0030, 16'h1234, 0);
    checkEq("ldst old value", lastDout, 16'h0007);
    drainIdle();
    checkEq("ldst new value", mem[16'h0030], 16'h1234);

    // Random traffic on a small address window; stalled requests are held.
    rw = 0; rr = 0; rf = 0; ra = '0; rdin = '0;
    for (int n = 0; n < 800; n++) begin
      if (!lastStall) begin
        rw   = 1'($urandom_range(0, 1));
        rr   = ($urandom_range(0, 2) == 0);
        ra   = 16'h0040 + 16'($urandom_range(0, 7));
        rdin = 16'($urandom);
        rf   = ($urandom_range(0, 24) == 0);
      end else begin
        rf = 0;
      end
      applyStimulus(rw, rr, ra, rdin, rf);
    end
    drainIdle();
    for (int a = 16'h40; a < 16'h48; a++) checkEq("random mem", mem[a], refMem[a]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-posting buffer directly upstream of the 16-bit data memory (1024 x 16, combinational read, write on clock edge).
- Accepts CPU stores into a small FIFO and drains them to memory when the memory port is free.
- Serves CPU loads straight from memory, or from the newest matching buffered store.
- Provides a flush handshake so the pipeline can force memory coherence.

Parameters:
DEPTH, 4, number of buffered stores; power of two, 2..16
PTR_W, 2, log2(DEPTH); pointer width

Ports:
Clock_Puls  input  1  clock; all state updates on rising edge
Reset_n  input  1  asynchronous, active-low reset
Cpu_Adr  input  16  CPU load/store word address
Cpu_Wr  input  1  store request
Cpu_Rd  input  1  load request
Cpu_Din  input  16  store data
Cpu_Dout  output  16  load data; 0 when Cpu_Rd=0 or stalled
Cpu_Stall  output  1  request not accepted this cycle; CPU holds inputs
Flush  input  1  single-cycle pulse: drain all entries
Flush_Done  output  1  single-cycle pulse when drain after Flush completes
Mem_Adr  output  16  to memory Adr
Mem_Wr  output  1  to memory Wr
Mem_Rd  output  1  to memory Rd
Mem_Di  output  16  to memory D_i
Mem_Do  input  16  from memory D_o (combinational)

Behaviour:
- Reset (Reset_n=0, async): head=tail=count=0, state IDLE, all entry valid bits 0, Flush_Done=0. Outputs while in reset: Mem_Wr=0, Mem_Rd=0, Mem_Adr=0, Mem_Di=0, Cpu_Stall=0, Cpu_Dout=0.
- Storage: FIFO of {adr[15:0], data[15:0]}; count is 0..DEPTH; pointers wrap modulo DEPTH.
- Memory port arbitration, one user per cycle, combinational outputs:
  - a) state FLUSH or count==DEPTH: drain head (Mem_Wr=1, Mem_Adr/Mem_Di=head entry).
  - b) else if Cpu_Rd: read (Mem_Rd=1, Mem_Adr=Cpu_Adr).
  - c) else if count>0: drain head.
  - d) else idle: Mem_Adr=0, Mem_Wr=0, Mem_Rd=0.
  - A drain pops the head at the edge.
- Cpu_Stall=1 when (Cpu_Wr|Cpu_Rd) and (state==FLUSH or count==DEPTH).
  - Stalled requests have no effect.
  - Full is resolved in one cycle, since the drain frees a slot.
- Store accepted (Cpu_Wr & !Cpu_Stall): enqueued at tail on the edge.
  - Push and pop in the same cycle leave count unchanged.
  - Zero-latency from the CPU's view.
- Load accepted: Cpu_Dout is combinational in the same cycle.
  - Source is the newest buffered entry with adr==Cpu_Adr (search tail-1 back to head), else Mem_Do.
  - A store presented in the same cycle is NOT visible to that load (enqueues at the edge).
- Cpu_Wr and Cpu_Rd together: both accepted if not stalled; the load completes before the store.
- State machine:
  - IDLE -> FLUSH on Flush=1.
  - FLUSH -> IDLE when count==0 after the edge; Flush_Done=1 for exactly that one cycle (registered).
  - Flush with count==0: FLUSH for one cycle, Flush_Done the next.
  - Flush while in FLUSH: ignored.
- Reset mid-operation: buffered stores are discarded, memory is untouched, no partial write.

Optional Feature:
- Macro: STORE_BUFFER_FORWARD_EN.
- Defined: load forwarding from buffered entries as above.
- Undefined: no forwarding comparators on the data path.
  - A load whose Cpu_Adr matches any valid entry asserts Cpu_Stall; the port drains instead.
  - The load is accepted once no entry matches; it then reads Mem_Do.
  - Non-matching loads behave identically in both builds.

Test Plan:
- Reset, then store 0x0010<-0xBEEF with no other traffic -> enqueued; next cycle Mem_Wr=1, Mem_Adr=0x0010, Mem_Di=0xBEEF; count returns to 0.
- Four back-to-back stores 0x0001..0x0004 with Cpu_Rd=1 to 0x0100 each cycle (data 0x1111 preloaded) -> loads return 0x1111, count reaches 4; the next store sees Cpu_Stall=1 for one cycle while Mem_Wr drains 0x0001, then is accepted.
- Stores 0x0020<-0xAAAA then 0x0020<-0x5555 buffered, load 0x0020 -> with FORWARD_EN Cpu_Dout=0x5555 same cycle; without it Cpu_Stall until both drain, then 0x5555 from memory.
- Three buffered entries, Flush pulse -> Cpu_Stall on every request; 3 consecutive Mem_Wr cycles; Flush_Done high exactly one cycle; then IDLE.
- Reset_n asserted low asynchronously between edges with 2 entries buffered -> Mem_Wr drops immediately; after release count=0 and memory unchanged at those addresses.
- Cpu_Wr and Cpu_Rd both asserted, same address 0x0030, old memory value 0x0007 -> Cpu_Dout=0x0007; store drains a later cycle writing the new value.
